// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   state_t   : control FSM states of alu_arbiter (IDLE/EXEC/RESP)
//   F_*       : 3-bit ALU function codes understood by module alu
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F_AND  = 3'b000;
  localparam logic [2:0] F_OR   = 3'b001;
  localparam logic [2:0] F_ADD  = 3'b010;
  localparam logic [2:0] F_DIV  = 3'b011;
  localparam logic [2:0] F_ANDN = 3'b100;
  localparam logic [2:0] F_ORN  = 3'b101;
  localparam logic [2:0] F_SUB  = 3'b110;
  localparam logic [2:0] F_SLT  = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU.
//   a, b : operands (unsigned)
//   f    : function code (alu_pkg::F_*)
//   y    : result; add/sub wrap, SLT is an unsigned compare zero-extended
//   zero : operands equal (a == b)
module alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   f,
  output logic [W-1:0] y,
  output logic         zero
);

  always_comb begin
    y = '0;
    unique case (f)
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      F_ADD:   y = a + b;
      F_DIV:   y = a / b;
      F_ANDN:  y = a & ~b;
      F_ORN:   y = a | ~b;
      F_SUB:   y = a - b;
      F_SLT:   y[0] = (a < b);
      default: y = '0;
    endcase
  end

  assign zero = (a == b);

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic (purely combinational).
//   valid : request lines, bit n = requester n
//   rr    : preferred requester when both are valid
//   grant : one-hot grant, or zero when nothing is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | ~rr);
  assign grant[1] = valid[1] & (~valid[0] |  rr);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
//   clk, rst           : clock, synchronous active-high reset
//   pN_valid/pN_ready  : operation handshake for requester N (ready only in IDLE)
//   pN_a, pN_b, pN_f   : operands and function code for requester N
//   rsp_valid/ready    : result handshake (valid only in RESP)
//   rsp_y, rsp_zero    : registered ALU result and A==B flag
//   rsp_id             : requester that owns the result
//   rsp_err            : divide by zero; rsp_y is then forced to all-ones
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_valid,
  output logic         p0_ready,
  input  logic [W-1:0] p0_a,
  input  logic [W-1:0] p0_b,
  input  logic [2:0]   p0_f,
  input  logic         p1_valid,
  output logic         p1_ready,
  input  logic [W-1:0] p1_a,
  input  logic [W-1:0] p1_b,
  input  logic [2:0]   p1_f,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_y,
  output logic         rsp_zero,
  output logic         rsp_id,
  output logic         rsp_err
);

  state_t         state, state_nxt;
  logic           rr;
  logic [1:0]     grant;
  logic           accept;
  logic [W-1:0]   op_a, op_b;
  logic [2:0]     op_f;
  logic           op_id;
  logic [W-1:0]   alu_y;
  logic           alu_zero;
  logic           div0;

  rr_arb2 u_arb (
    .valid ({p1_valid, p0_valid}),
    .rr    (rr),
    .grant (grant)
  );

  alu #(.W(W)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .f    (op_f),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Divide-by-zero overrides the ALU divide output.
  assign div0 = (op_f == F_DIV) && (op_b == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    p0_ready  = 1'b0;
    p1_ready  = 1'b0;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Readies are masked during reset so nothing is accepted then.
        if (!rst) begin
          p0_ready = grant[0];
          p1_ready = grant[1];
          accept   = |grant;
        end
        if (accept) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr       <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_f     <= '0;
      op_id    <= 1'b0;
      rsp_y    <= '0;
      rsp_zero <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= grant[1] ? p1_a : p0_a;
        op_b  <= grant[1] ? p1_b : p0_b;
        op_f  <= grant[1] ? p1_f : p0_f;
        op_id <= grant[1];
        // Point at the requester that was not served.
        rr    <= grant[0];
      end
      if (state == S_EXEC) begin
        rsp_y    <= div0 ? '1 : alu_y;
        rsp_zero <= alu_zero;
        rsp_id   <= op_id;
        rsp_err  <= div0;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width passed to the shared ALU instance.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports p0_valid, p1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have ports p0_ready, p1_ready  output  1 each  operation accepted this cycle when ready&valid.
REQ-006 SHALL have ports p0_a, p0_b, p1_a, p1_b  input  W each  operands A, B per requester.
REQ-007 SHALL have ports p0_f, p1_f  input  3 each  ALU function code (000 AND … 111 SLT, ALU encoding).
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_y  output  W  registered ALU result.
REQ-011 SHALL have port rsp_zero  output  1  registered ALU zero flag (A==B).
REQ-012 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-013 SHALL have port rsp_err  output  1  set for divide (F=011) with B==0.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 SHALL, in IDLE, assert at most one pN_ready, combinationally, for the granted valid requester; no ready in EXEC/RESP.
REQ-016 SHALL grant the sole valid requester; when both are valid, grant the requester pointed to by round-robin pointer rr.
REQ-017 SHALL, after each accepted handshake, set rr to the non-granted index; rr unchanged when nothing is accepted.
REQ-018 SHALL, on handshake in cycle N, latch A, B, F and id into operand registers and enter EXEC at N+1.
REQ-019 SHALL, in EXEC, drive latched operands into one shared ALU, register Y/zero/err/id into rsp_* and enter RESP at N+2.
REQ-020 SHALL assert rsp_valid only in RESP and hold all rsp_* stable until rsp_valid&rsp_ready.
REQ-021 SHALL return to IDLE the cycle after rsp handshake; minimum issue interval 3 cycles.
REQ-022 SHALL, for F=011 and B==0, force rsp_y to all-ones and rsp_err=1 instead of using ALU divide output; rsp_err=0 otherwise.
REQ-023 SHALL ignore pN_a/b/f changes while not in IDLE; requesters keep valid asserted until ready.
REQ-024 SHALL treat results as W-bit unsigned, wrap-around on add/sub; SLT unsigned compare, result 1 or 0 zero-extended.

Reset
REQ-025 SHALL on rst: state=IDLE, rr=0, rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_id=0, rsp_err=0, operand regs=0.
REQ-026 SHALL abandon any in-flight operation on rst asserted in EXEC or RESP; no result delivered afterwards.
REQ-027 SHALL drive p0_ready=p1_ready=0 during the rst cycle.

Structure
REQ-028 SHALL place FSM state encoding and ALU function-code constants (F_AND..F_SLT) in shared package alu_pkg.
REQ-029 SHALL instantiate exactly one existing ALU module as the shared datapath; no duplicate arithmetic except the B==0 check.
REQ-030 SHALL implement grant logic as sub-module rr_arb2 (inputs valid[1:0], rr; output grant[1:0], one-hot or zero).

Verification
REQ-031 SHALL cover: p0 only, A=5,B=3,F=010 -> p0_ready cycle N, rsp_valid N+2, rsp_y=8, rsp_id=0, rsp_zero=0.
REQ-032 SHALL cover: both valid every cycle after reset, 4 ops -> grant order p0,p1,p0,p1.
REQ-033 SHALL cover: p1 A=7,B=0,F=011 -> rsp_y=FFFFFFFF, rsp_err=1, rsp_id=1.
REQ-034 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_* stable, no pN_ready, p0 waiting accepted the cycle after rsp handshake+1.
REQ-035 SHALL cover: A=B=9,F=110 -> rsp_y=0, rsp_zero=1; A=2,B=9,F=111 -> rsp_y=1; A=0,B=1,F=110 -> rsp_y=FFFFFFFF.
REQ-036 SHALL cover: rst asserted in EXEC -> next cycle IDLE, rsp_valid stays 0, rr=0 (p0 wins next tie).
